rst_sync: RTL and testbench



---
 rtl/rst_sync_pkg.sv | 19 +
 rtl/rst_sync_stage.sv | 37 +++
 rtl/rst_sync.sv | 79 +++++++
 tb/tb_rst_sync.sv | 139 +++++++++++++
 4 files changed

// File: rtl/rst_sync_pkg.sv
// rst_sync_pkg: constants shared by the reset synchronizer and its stage flop.
// Build option: RST_SYNC_ASSERT_EN enables simulation-only checkers in rst_sync.
`timescale 1ns/1ps

package rst_sync_pkg;

    // Legal depth of the synchronizing chain.
    localparam int RST_SYNC_MIN_STAGES = 2;
    localparam int RST_SYNC_MAX_STAGES = 8;

    // Reset is active-low on both the input pin and the synchronized output.
    localparam logic RST_ACTIVE = 1'b0;

    // True when a requested chain depth is within the legal range.
    function automatic bit rst_sync_stages_legal(input int num_stages);
        return (num_stages >= RST_SYNC_MIN_STAGES) && (num_stages <= RST_SYNC_MAX_STAGES);
    endfunction

endpackage : rst_sync_pkg

// File: rtl/rst_sync_stage.sv
// rst_sync_stage: one flop of the reset synchronizer chain.
// Rising-edge D flop with an asynchronous clear driven by the raw reset.
// The flop is marked so implementation tools keep it, place it next to its
// neighbours in the chain, and never retime or duplicate it.
`timescale 1ns/1ps

module rst_sync_stage
    import rst_sync_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    logic q_d;
    (* ASYNC_REG = "TRUE", keep = "true", dont_touch = "true" *)
    logic q_q;

    // Next value is simply the previous stage (or the constant release level).
    always_comb q_d = D;

    // Stage register: clears immediately on reset, samples D on each rising edge.
    // NOTE: sequential state uses non-blocking (<=) so every stage samples its
    // neighbour's pre-edge value; blocking here would collapse the chain.
    always_ff @(posedge CLK or negedge RST) begin
        if (RST == RST_ACTIVE) begin
            q_q <= RST_ACTIVE;
        end else begin
            q_q <= q_d;
        end
    end

    // Output straight from the flop, so no combinational glitch reaches it.
    assign Q = q_q;

endmodule : rst_sync_stage

// File: rtl/rst_sync.sv
// rst_sync: reset synchronizer for one clock domain.
// RST (async, active-low) clears every stage at once, so SYNC_RST asserts
// with zero clock latency. After RST rises, a '1' ripples through
// NUM_STAGES flops and SYNC_RST deasserts on the NUM_STAGES-th rising edge.
// Build option: define RST_SYNC_ASSERT_EN to include simulation-only checkers;
// the synthesized logic is identical either way.
`timescale 1ns/1ps

module rst_sync
    import rst_sync_pkg::*;
#(
    parameter int NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    output logic SYNC_RST
);

    // Reject illegal chain depths while elaborating.
    if (!rst_sync_stages_legal(NUM_STAGES)) begin : g_bad_depth
        $error("rst_sync: NUM_STAGES=%0d outside legal range %0d..%0d",
               NUM_STAGES, RST_SYNC_MIN_STAGES, RST_SYNC_MAX_STAGES);
    end

    logic [NUM_STAGES-1:0] stage_d;
    logic [NUM_STAGES-1:0] stage_q;

    // Chain wiring: stage[0] loads the release level, stage[i] loads stage[i-1].
    // NOTE: every always_comb output gets a full assignment on every path, so
    // no latch can be inferred.
    always_comb begin
        stage_d = {stage_q[NUM_STAGES-2:0], ~RST_ACTIVE};
    end

    // Chain of identical async-clear flops, all cleared directly by RST.
    // NOTE: the async clear is the only reset these flops need; the chain
    // itself is what turns it into a synchronous release.
    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        rst_sync_stage u_stage (
            .CLK (CLK),
            .RST (RST),
            .D   (stage_d[i]),
            .Q   (stage_q[i])
        );
    end

    // Output comes directly from the last flop: no logic on this path.
    assign SYNC_RST = stage_q[NUM_STAGES-1];

`ifdef RST_SYNC_ASSERT_EN
    // Simulation-only checkers on the synchronized reset.
    realtime last_clk_rise_t;

    // Remember when the destination clock last rose.
    always @(posedge CLK) last_clk_rise_t = $realtime;

    // While RST is asserted, the output must be asserted too.
    always @(posedge CLK or negedge CLK) begin
        if (RST == RST_ACTIVE) begin
            assert (SYNC_RST == RST_ACTIVE)
                else $error("rst_sync: SYNC_RST released while RST asserted");
        end
    end

    // Release may only happen on a rising clock edge.
    always @(posedge SYNC_RST) begin
        assert (last_clk_rise_t == $realtime)
            else $error("rst_sync: SYNC_RST rose away from a CLK rising edge");
    end

    // Once released, the output may only fall because RST fell.
    always @(negedge SYNC_RST) begin
        assert (RST == RST_ACTIVE)
            else $error("rst_sync: SYNC_RST fell without RST asserted");
    end
`else
`endif

endmodule : rst_sync

// File: tb/tb_rst_sync.sv
// tb_rst_sync: directed bench for rst_sync at depths 4 and 2 sharing CLK/RST.
`timescale 1ns/1ps

module tb_rst_sync;

    logic CLK;
    logic RST;
    logic clk_en;
    logic sync4;
    logic sync2;

    int checks = 0;
    int errors = 0;

    rst_sync #(.NUM_STAGES(4)) dut4 (
        .CLK      (CLK),
        .RST      (RST),
        .SYNC_RST (sync4)
    );

    rst_sync #(.NUM_STAGES(2)) dut2 (
        .CLK      (CLK),
        .RST      (RST),
        .SYNC_RST (sync2)
    );

    // 10 ns clock; toggles only while clk_en is set (ticks on multiples of 5 ns).
    initial begin
        CLK = 1'b0;
        forever begin
            #5;
            if (clk_en) CLK = ~CLK;
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    // After a release between edges, both outputs must rise on exactly
    // the NUM_STAGES-th following rising edge and stay high.
    task automatic release_check(input string tag);
        for (int e = 1; e <= 6; e++) begin
            @(posedge CLK);
            #1;
            check($sformatf("%s_n4_e%0d", tag, e), sync4, (e >= 4) ? 1'b1 : 1'b0);
            check($sformatf("%s_n2_e%0d", tag, e), sync2, (e >= 2) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        // Power-up, then assert reset without any clock edge yet.
        clk_en = 1'b1;
        RST    = 1'b1;
        #1 RST = 1'b0;
        #1;
        check("async_assert_n4", sync4, 1'b0);
        check("async_assert_n2", sync2, 1'b0);

        // Held in reset until t=100: outputs stay low on every edge.
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK);
            #1;
            check($sformatf("in_reset_n4_%0d", k), sync4, 1'b0);
            check($sformatf("in_reset_n2_%0d", k), sync2, 1'b0);
        end
        wait ($time >= 100);
        RST = 1'b1;
        release_check("init_release");

        // One-period pulse, not aligned to the clock.
        @(posedge CLK);
        #3 RST = 1'b0;
        #0.001;
        check("pulse10_assert_n4", sync4, 1'b0);
        check("pulse10_assert_n2", sync2, 1'b0);
        #9.999 RST = 1'b1;
        check("pulse10_held_n4", sync4, 1'b0);
        release_check("pulse10");

        // 2 ns pulse between edges.
        @(posedge CLK);
        #3 RST = 1'b0;
        #0.001;
        check("pulse2_assert_n4", sync4, 1'b0);
        check("pulse2_assert_n2", sync2, 1'b0);
        #1.999 RST = 1'b1;
        release_check("pulse2");

        // Re-assert two edges into a release; count must restart.
        @(posedge CLK);
        #3 RST = 1'b0;
        @(posedge CLK);
        #2 RST = 1'b1;
        @(posedge CLK);
        #1;
        check("mid_e1_n4", sync4, 1'b0);
        @(posedge CLK);
        #1;
        check("mid_e2_n4", sync4, 1'b0);
        check("mid_e2_n2", sync2, 1'b1);
        #2 RST = 1'b0;
        #0.001;
        check("mid_reassert_n4", sync4, 1'b0);
        check("mid_reassert_n2", sync2, 1'b0);
        #4 RST = 1'b1;
        release_check("mid_restart");

        // Clock stopped: reset toggles, outputs go low and stay low.
        @(posedge CLK);
        #3 clk_en = 1'b0;
        #1 RST = 1'b0;
        #1;
        check("stopped_assert_n4", sync4, 1'b0);
        check("stopped_assert_n2", sync2, 1'b0);
        #20 RST = 1'b1;
        #50;
        check("stopped_hold_n4", sync4, 1'b0);
        check("stopped_hold_n2", sync2, 1'b0);
        #2 clk_en = 1'b1;
        release_check("clk_resume");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rst_sync
